// File: rtl/qvalue_selector_if.sv
// Byte-addressed neighbour-table memory bus: single address/write port, combinational read data.
interface qvalue_selector_if;
    logic [15:0] mem_address;
    logic        mem_wr_en;
    logic [15:0] mem_data_out;
    logic [15:0] mem_data_in;

    modport master (output mem_address, output mem_wr_en, output mem_data_out, input mem_data_in);
    modport slave  (input mem_address, input mem_wr_en, input mem_data_out, output mem_data_in);
endinterface

// File: rtl/qvalue_selector.sv
// Scans the qValue table for the highest unsigned qValue (lowest index on ties), fetches
// that neighbour's ID and writes ID and qValue back to the nextsink / better_qvalue slots.
module qvalue_selector #(
    parameter logic [15:0] QVALUE_BASE   = 16'h01C8,
    parameter logic [15:0] NEIGHBOR_BASE = 16'h0048,
    parameter logic [15:0] NEXTSINK_ADDR = 16'h0700,
    parameter logic [15:0] BETTERQ_ADDR  = 16'h0710,
    parameter int          MAX_NEIGHBORS = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [6:0]                neighbor_count,
    qvalue_selector_if.master         mem,
    output logic                      busy,
    output logic                      done,
    output logic                      valid,
    output logic [5:0]                best_index,
    output logic [15:0]               best_id,
    output logic [15:0]               best_qvalue
);

    typedef enum logic [2:0] {IDLE, READ_Q, READ_ID, WRITE_ID, WRITE_Q, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        found_q, found_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        valid_q, valid_d;
    logic [5:0]  best_index_q, best_index_d;
    logic [15:0] best_id_q, best_id_d;
    logic [15:0] best_qvalue_q, best_qvalue_d;

    logic [6:0]  cnt_clamped;
    logic        last;

    assign cnt_clamped = (neighbor_count > 7'(MAX_NEIGHBORS)) ? 7'(MAX_NEIGHBORS) : neighbor_count;
    assign last        = ({1'b0, idx_q} == (cnt_q - 7'd1));

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        found_d       = found_q;
        valid_d       = valid_q;
        best_index_d  = best_index_q;
        best_id_d     = best_id_q;
        best_qvalue_d = best_qvalue_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d         = cnt_clamped;
                    idx_d         = '0;
                    found_d       = 1'b0;
                    valid_d       = 1'b0;
                    best_index_d  = '0;
                    best_id_d     = '0;
                    best_qvalue_d = '0;
                    state_d       = (cnt_clamped == 7'd0) ? DONE : READ_Q;
                end
            end
            READ_Q: begin
                // Strict compare keeps the earliest index on ties.
                if (!found_q || (mem.mem_data_in > best_qvalue_q)) begin
                    best_qvalue_d = mem.mem_data_in;
                    best_index_d  = idx_q;
                    found_d       = 1'b1;
                    state_d       = READ_ID;
                end else if (last) begin
                    state_d = WRITE_ID;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            READ_ID: begin
                best_id_d = mem.mem_data_in;
                if (last) begin
                    state_d = WRITE_ID;
                end else begin
                    idx_d   = idx_q + 6'd1;
                    state_d = READ_Q;
                end
            end
            WRITE_ID: state_d = WRITE_Q;
            WRITE_Q:  state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        // Status outputs are registered, so they are computed from the next state.
        if (state_d == DONE && state_q != DONE) valid_d = found_d;
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            found_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            valid_q       <= 1'b0;
            best_index_q  <= '0;
            best_id_q     <= '0;
            best_qvalue_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            found_q       <= found_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            valid_q       <= valid_d;
            best_index_q  <= best_index_d;
            best_id_q     <= best_id_d;
            best_qvalue_q <= best_qvalue_d;
        end
    end

    // Memory port decodes straight from state so reads see data in the same cycle.
    always_comb begin
        mem.mem_address  = 16'h0000;
        mem.mem_data_out = 16'h0000;
        mem.mem_wr_en    = 1'b0;
        case (state_q)
            READ_Q:   mem.mem_address = QVALUE_BASE + {9'd0, idx_q, 1'b0};
            READ_ID:  mem.mem_address = NEIGHBOR_BASE + {9'd0, idx_q, 1'b0};
            WRITE_ID: begin
                mem.mem_address  = NEXTSINK_ADDR;
                mem.mem_data_out = best_id_q;
                mem.mem_wr_en    = ~reset;
            end
            WRITE_Q: begin
                mem.mem_address  = BETTERQ_ADDR;
                mem.mem_data_out = best_qvalue_q;
                mem.mem_wr_en    = ~reset;
            end
            default: ;
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign valid       = valid_q;
    assign best_index  = best_index_q;
    assign best_id     = best_id_q;
    assign best_qvalue = best_qvalue_q;

endmodule
